load_store_unit: RTL and testbench

//  Initiator side of the word-wide data memory port: accepts one byte-addressed load/store request
//  at a time, drives MemRead/MemWrite/addr/data_in to the memory, and captures data_out.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/load_store_unit_align.sv | 56 +++++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and the decode stage:
//   - RISC-V load/store funct3 encodings (F3_B .. F3_HU)
//   - load/store unit FSM state encoding
//   - small helper to classify halfword accesses
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    function automatic logic is_half(input logic [2:0] funct3);
        return (funct3 == F3_H) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// ----------------------------------------------------------------------------
// load_store_unit_align (module lsu_align)
// Purely combinational lane handling for a word-only memory.
//   load_word  in  32  word read from memory this cycle
//   old_word   in  32  word latched by the read half of a read-modify-write
//   wdata      in  32  store data, right-aligned
//   byte_off   in  2   byte address bits [1:0]
//   funct3     in  3   access size / signedness
//   load_data  out 32  selected lane, sign- or zero-extended
//   store_word out 32  old_word with the addressed lane replaced (full word for SW)
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte lane is picked by both offset bits, halfword lane only by bit 1.
    always_comb begin
        ld_byte   = load_word[{byte_off, 3'b000} +: 8];
        ld_half   = byte_off[1] ? load_word[31:16] : load_word[15:0];
        load_data = load_word;
        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'h0, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'h0, ld_half};
            default: load_data = load_word;
        endcase
    end

    // Merge keeps the untouched lanes of the previously read word.
    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the word-wide data memory port. Takes one byte-addressed
// load/store at a time, performs byte/halfword stores as read-modify-write,
// extends load data and flags misaligned, out-of-range or illegal requests.
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_we/funct3/addr/wdata   request contents, registered on accept
//   resp_valid                 one-cycle completion pulse
//   resp_rdata/resp_err        extended load data / error flag, held to next resp
//   mem_read/mem_write         memory strobes, decoded from state
//   mem_addr/mem_wdata         word address and write data (0 when not accessing)
//   mem_rdata                  combinational memory read data
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t          state;
    lsu_state_t          state_next;
    logic                accept;
    logic                req_err;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word_q;
    logic [31:0]         load_data;
    logic [31:0]         store_word;

    assign accept = req_valid && (state == ST_IDLE);

    // Errors are judged on the raw request so an erroneous access never
    // touches memory; it goes straight to the response state.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B:    req_err = 1'b0;
            F3_BU:   req_err = req_we;
            F3_H:    req_err = req_addr[0];
            F3_HU:   req_err = req_we || req_addr[0];
            F3_W:    req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (req_addr[31:ADDR_W+2] != '0)
            req_err = 1'b1;
    end

    lsu_align u_align (
        .load_word  (mem_rdata),
        .old_word   (word_q),
        .wdata      (wdata_q),
        .byte_off   (addr_q[1:0]),
        .funct3     (funct3_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state plus Moore decode of all memory-side and handshake outputs.
    // Full-word stores skip the read; sub-word stores read first to merge.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD: begin
                mem_read   = 1'b1;
                mem_addr   = addr_q[ADDR_W+1:2];
                state_next = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_write  = 1'b1;
                mem_addr   = addr_q[ADDR_W+1:2];
                mem_wdata  = store_word;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture on accept, and the word latched during the read half
    // of a read-modify-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDR_W+1:0];
                wdata_q  <= req_wdata;
            end
            if (state == ST_RD)
                word_q <= mem_rdata;
        end
    end

    // Response data only changes on the edge entering RESP, so it is held
    // stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept && req_err) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end
            if ((state == ST_RD) && !we_q) begin
                resp_rdata <= load_data;
                resp_err   <= 1'b0;
            end
            if (state == ST_WR) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: behavioural word memory, a reference model of each
// request computed from byte/halfword arithmetic, and one per-cycle compare
// process checking the DUT against the model's expected access schedule.
// ----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 6;
    localparam int WORDS  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = '0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural data memory: combinational read, write on rising edge.
    logic [31:0] mem [WORDS];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    logic [31:0] refMem [WORDS];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Outstanding expectation (at most one request in flight).
    bit          pending = 0;
    int          rdCyc, wrCyc, respCyc, acceptCyc;
    int          lastRespCyc = -10;
    logic [31:0] expRdata, expWord, lastRdata = '0;
    logic [5:0]  expIdx;
    bit          expErr, expCommit;
    logic [31:0] obsRdata;
    bit          obsErr;
    int          obsCyc, lat;
    int          rdCnt = 0, wrCnt = 0;
    bit          prevResp = 0;
    bit          eRd, eWr, eResp;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: outcome of one request from size/offset arithmetic.
    function automatic void modelReq(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] word,
                                     output bit err, output logic [31:0] rdata,
                                     output logic [31:0] nw, output bit rd, output bit wr);
        int size, off;
        bit uns;
        logic [31:0] mask, val;
        off = int'(addr % 4);
        uns = 0;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; end
            3'd5: begin size = 2; uns = 1; end
            default: size = 0;
        endcase
        err = 0; rdata = '0; nw = word; rd = 0; wr = 0;
        if (size == 0) err = 1;
        else if (off % size != 0) err = 1;
        if (addr >= 32'(4 * WORDS)) err = 1;
        if (we && uns) err = 1;
        if (err) return;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((size == 1) ? 32'hFF : 32'hFFFF);
        if (!we) begin
            rd  = 1;
            val = (word >> (8 * off)) & mask;
            if (!uns && size < 4 && val[8 * size - 1]) val = val | ~mask;
            rdata = val;
        end else begin
            wr   = 1;
            rd   = (size < 4);
            mask = mask << (8 * off);
            nw   = (word & ~mask) | ((wdata << (8 * off)) & mask);
        end
    endfunction

    // Present a request and hold it until the model says the unit is idle,
    // then record what the accepted request must do. req_valid stays high.
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        bit e, r, w;
        logic [31:0] rd, nw;
        int k;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        k = 0;
        while ((pending || cyc == lastRespCyc) && k < 40) begin
            @(negedge clk); #1; k++;
        end
        if (pending || cyc == lastRespCyc) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
            pending = 0;
            lastRespCyc = -10;
        end
        modelReq(we, f3, addr, wdata, refMem[addr[7:2]], e, rd, nw, r, w);
        @(posedge clk); #1;
        acceptCyc = cyc;
        rdCyc     = r ? acceptCyc : -1;
        wrCyc     = w ? (r ? acceptCyc + 1 : acceptCyc) : -1;
        respCyc   = acceptCyc + int'(r) + int'(w);
        expRdata  = rd;
        expErr    = e;
        expWord   = nw;
        expIdx    = addr[7:2];
        expCommit = w;
        pending   = 1;
    endtask

    task automatic waitResp();
        int k;
        k = 0;
        while (pending && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (pending) begin
            checkOutput("resp_timeout", 32'd1, 32'd0);
            pending = 0;
        end
        lat = obsCyc - acceptCyc + 1;
    endtask

    task automatic doReq(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        applyStimulus(we, f3, addr, wdata);
        waitResp();
        req_valid = 1'b0;
    endtask

    always @(negedge clk) if (rst_n) begin
        rdCnt += int'(mem_read);
        wrCnt += int'(mem_write);
    end

    // Per-cycle comparison of DUT outputs against the model's schedule.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevResp = 0;
        end else begin
            eRd   = pending && (cyc == rdCyc);
            eWr   = pending && (cyc == wrCyc);
            eResp = pending && (cyc == respCyc);
            checkOutput("req_ready", 32'(req_ready), 32'(!pending));
            checkOutput("mem_read", 32'(mem_read), 32'(eRd));
            checkOutput("mem_write", 32'(mem_write), 32'(eWr));
            checkOutput("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
            checkOutput("resp_valid", 32'(resp_valid), 32'(eResp));
            if (prevResp) checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
            if (eRd || eWr) checkOutput("mem_addr", 32'(mem_addr), 32'(expIdx));
            if (eWr) checkOutput("mem_wdata", mem_wdata, expWord);
            if (!eRd && !eWr) begin
                checkOutput("mem_addr_idle", 32'(mem_addr), 32'd0);
                checkOutput("mem_wdata_idle", mem_wdata, 32'd0);
            end
            if (eResp) begin
                checkOutput("resp_rdata", resp_rdata, expRdata);
                checkOutput("resp_err", 32'(resp_err), 32'(expErr));
                obsRdata    = resp_rdata;
                obsErr      = resp_err;
                obsCyc      = cyc;
                lastRdata   = expRdata;
                lastRespCyc = cyc;
                if (expCommit) refMem[expIdx] = expWord;
                pending = 0;
            end else begin
                checkOutput("resp_rdata_hold", resp_rdata, lastRdata);
            end
            prevResp = resp_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rb, wb, bad;
        for (int i = 0; i < WORDS; i++) begin
            refMem[i] = $urandom;
            mem[i]    = refMem[i];
        end
        refMem[4] = 32'hD5CE5328;
        mem[4]    = 32'hD5CE5328;

        // Reset values, asserted asynchronously between edges.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        checkOutput("rst_mem_addr_wdata", mem_wdata | 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Loads from the preloaded word.
        doReq(0, F3_B, 32'h13, 0);
        checkOutput("LB_rdata", obsRdata, 32'hFFFFFFD5);
        checkOutput("LB_err", 32'(obsErr), 32'd0);
        checkOutput("LB_latency", 32'(lat), 32'd2);
        doReq(0, F3_BU, 32'h13, 0);
        checkOutput("LBU_rdata", obsRdata, 32'h000000D5);
        doReq(0, F3_H, 32'h12, 0);
        checkOutput("LH_rdata", obsRdata, 32'hFFFFD5CE);

        // Byte store by read-modify-write.
        rb = rdCnt; wb = wrCnt;
        doReq(1, F3_B, 32'h11, 32'h000000AB);
        checkOutput("SB_latency", 32'(lat), 32'd3);
        checkOutput("SB_reads", 32'(rdCnt - rb), 32'd1);
        checkOutput("SB_writes", 32'(wrCnt - wb), 32'd1);
        checkOutput("SB_memword", mem[4], 32'hD5CEAB28);
        doReq(0, F3_W, 32'h10, 0);
        checkOutput("LW_after_SB", obsRdata, 32'hD5CEAB28);

        // Full-word store needs no read.
        rb = rdCnt; wb = wrCnt;
        doReq(1, F3_W, 32'h14, 32'h12345678);
        checkOutput("SW_latency", 32'(lat), 32'd2);
        checkOutput("SW_reads", 32'(rdCnt - rb), 32'd0);
        checkOutput("SW_writes", 32'(wrCnt - wb), 32'd1);
        doReq(0, F3_W, 32'h14, 0);
        checkOutput("LW_after_SW", obsRdata, 32'h12345678);

        // Error cases: no memory activity, response one cycle after accept.
        rb = rdCnt; wb = wrCnt;
        doReq(0, F3_W, 32'h06, 0);
        checkOutput("ERR_LW_mis_err", 32'(obsErr), 32'd1);
        checkOutput("ERR_LW_mis_lat", 32'(lat), 32'd1);
        doReq(1, F3_H, 32'h11, 32'hBEEF);
        checkOutput("ERR_SH_mis_err", 32'(obsErr), 32'd1);
        doReq(0, F3_W, 32'h100, 0);
        checkOutput("ERR_range_err", 32'(obsErr), 32'd1);
        checkOutput("ERR_range_lat", 32'(lat), 32'd1);
        doReq(0, 3'b011, 32'h10, 0);
        checkOutput("ERR_f3_err", 32'(obsErr), 32'd1);
        checkOutput("ERR_mem_activity", 32'((rdCnt - rb) + (wrCnt - wb)), 32'd0);

        // Reset dropped during the write cycle of a byte store.
        applyStimulus(1, F3_B, 32'h11, 32'h000000FF);
        req_valid = 1'b0;
        @(posedge clk); #2;
        checkOutput("RST_wr_active", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        pending = 0;
        lastRdata = '0;
        lastRespCyc = -10;
        checkOutput("RST_wr_dropped", 32'(mem_write), 32'd0);
        checkOutput("RST_ready", 32'(req_ready), 32'd1);
        checkOutput("RST_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("RST_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        checkOutput("RST_memword", mem[4], 32'hD5CEAB28);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        doReq(0, F3_W, 32'h10, 0);
        checkOutput("RST_LW_after", obsRdata, 32'hD5CEAB28);

        // Back-to-back requests with req_valid held high.
        applyStimulus(0, F3_HU, 32'h12, 0);
        applyStimulus(1, F3_H, 32'h22, 32'h0000CAFE);
        applyStimulus(0, F3_W, 32'h20, 0);
        waitResp();
        req_valid = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            bit w;
            logic [2:0] f;
            w = (($urandom % 3) == 0);
            f = 3'($urandom % 8);
            a = {24'h0, 6'($urandom % 64), 2'($urandom % 4)};
            if (($urandom % 12) == 0) a[8 + ($urandom % 24)] = 1'b1;
            doReq(w, f, a, $urandom);
            repeat ($urandom % 3) @(negedge clk);
        end

        bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== refMem[i]) bad++;
        checkOutput("final_memory", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
